hsi_byte_coder: RTL and testbench
=================================

# hsi_byte_coder

Downstream stage of the message byte producers (board-time-code controller and siblings) on the HSI transmit path. Accepts one byte at a time over a level-valid/busy handshake, frames it (start bit, 8 data bits MSB first, optional odd parity, stop gap) and drives it onto the line Manchester-encoded. Its `cd_busy` output is the producer's `cd_busy` input; the producer advances its byte counter on the rising edge of `cd_busy`.

## Interface
- `HALF_BIT_TICKS`, default 4: clocks per Manchester half-bit; legal range 1..255.
- `clk`  in  1  system clock.
- `n_rst`  in  1  asynchronous active-low reset.
- `tx_en`  in  1  message in progress; bytes are accepted only while high.
- `d`  in  8  byte from producer (its `q`).
- `d_rdy`  in  1  byte valid, level (producer's `q_rdy`).
- `cd_busy`  out  1  frame in progress; reset 0.
- `sdo`  out  1  Manchester line output; reset 0.
- `sdo_oe`  out  1  line driver enable, high from start bit through last data/parity bit; reset 0.
- `frame_done`  out  1  one-clock pulse at end of stop gap; reset 0.

## Operation
- States: IDLE, START, DATA, PAR (only when parity is compiled in), STOP.
- IDLE: `cd_busy`=0, `sdo`=0, `sdo_oe`=0. Accept when `tx_en & d_rdy` at a clock edge. Latch `d` into the shift register, compute parity, go to START.
- Bit encoding: '1' = high for the first half-bit, low for the second; '0' = low then high.
- START: one bit of value '1'.
- DATA: 8 bits, `d[7]` first; a 3-bit index counts 7 down to 0.
- PAR: odd parity, so the bit equals `~^d_latched`.
- STOP: `sdo`=0 and `sdo_oe`=0 for one full bit period. At its last tick, pulse `frame_done`, drop `cd_busy` and return to IDLE.
- Half-bit counter: 8 bits, counts 0..HALF_BIT_TICKS-1 and wraps; a phase flag toggles on each wrap. The bit advances when the phase flag goes from second half to first half.
- `d` is don't-care after the latch edge. The producer may change `q` during the frame.
- `tx_en` falling mid-frame: the current frame completes and no further byte is accepted.
- `n_rst` low mid-frame: all outputs go to 0 immediately and the state goes to IDLE. The partial frame is lost and is not replayed.
- `d_rdy` high while busy: ignored.

## Timing
- Latency: accept edge E. `cd_busy`, `sdo_oe` and the START first half on `sdo` are all registered high from E+1.
- Frame length: (1+8+P+1)·2·HALF_BIT_TICKS clocks, with P=1 if parity is compiled in. At defaults this is 88 clocks with parity, 80 without.
- `cd_busy` is high exactly for the frame length, then low for at least 1 clock. With `tx_en` and `d_rdy` held, the next accept is at the first edge where `cd_busy`=0. The back-to-back gap is therefore exactly 1 clock of `cd_busy` low.
- `frame_done` is high in the same clock `cd_busy` first reads 0.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `HSI_CODER_PARITY_EN` defined: PAR state is present, frames are 11 bits, odd parity.
- Undefined: PAR state and parity logic are removed, frames are 10 bits, DATA goes directly to STOP.
- This macro and the receiver's parity check macro must match across the link.

## Structure
- Shared `msg_defs.vh` holds:
  - state encodings `CODER_ST_IDLE/START/DATA/PAR/STOP`;
  - `CODER_START_BIT`;
  - the default `HALF_BIT_TICKS` value;
  - the frame-length constant used by producers' timeouts.
- One sub-module, `hsi_halfbit_tick`: the half-bit counter plus phase flag. It has inputs `clk`, `n_rst`, `run` and outputs `tick`, `second_half`. It is cleared while `run`=0.

## Test plan
- Reset: hold `n_rst`=0 with `d_rdy`=1, `tx_en`=1. All outputs are 0. Release `n_rst`; the accept happens on the next edge and `cd_busy`=1 one clock later.
- Single byte 0xA5, HALF_BIT_TICKS=2, parity on:
  - `sdo` shows start 10, then data 10 01 10 01 01 10 01 10, then parity 10 (0xA5 has four ones, so the bit is 1), then 00 stop;
  - each symbol lasts 2 clocks;
  - `cd_busy` is high for 44 clocks;
  - `frame_done` pulses once.
- Same 0xA5 with the macro undefined: parity symbol absent, `cd_busy` high for 40 clocks.
- Back-to-back 0x00 then 0xFF with `tx_en` held and the producer model incrementing on `cd_busy` rise:
  - `cd_busy` low for exactly 1 clock between frames;
  - second frame data symbols all 10;
  - the parity bit is 1 for 0x00 and 1 for 0xFF.
- `tx_en` dropped at clock 10 of a frame: the frame completes unchanged and no new accept follows while `d_rdy`=1.
- `n_rst` pulsed low at clock 20 of a frame: `sdo`, `sdo_oe` and `cd_busy` go to 0 asynchronously; after release a fresh byte 0x3C frames correctly from START.

Source files
------------

// File: rtl/hsi_byte_coder_pkg.sv
// Shared HSI byte-coder definitions: FSM states, start bit, default timing and frame length.
// Parity support is selected by HSI_CODER_PARITY_EN.
package hsi_byte_coder_pkg;

   typedef enum logic [2:0] {
      CODER_ST_IDLE,
      CODER_ST_START,
      CODER_ST_DATA,
`ifdef HSI_CODER_PARITY_EN
      CODER_ST_PAR,
`endif
      CODER_ST_STOP
   } coder_state_t;

   localparam logic CODER_START_BIT = 1'b1;
   localparam int unsigned CODER_HALF_BIT_TICKS_DEF = 4;

`ifdef HSI_CODER_PARITY_EN
   localparam int unsigned CODER_PAR_BITS = 1;
`else
   localparam int unsigned CODER_PAR_BITS = 0;
`endif

   localparam int unsigned CODER_FRAME_BITS = 1 + 8 + CODER_PAR_BITS + 1;
   // Producers size their timeouts from this frame length at default timing.
   localparam int unsigned CODER_FRAME_CLKS = CODER_FRAME_BITS * 2 * CODER_HALF_BIT_TICKS_DEF;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/hsi_byte_coder_halfbit_tick.sv
// Half-bit timer for the HSI byte coder: counter wrapping at HALF_BIT_TICKS plus phase flag.
// Held cleared while run is low.
module hsi_halfbit_tick
   import hsi_byte_coder_pkg::*;
#(
   parameter int unsigned HALF_BIT_TICKS = CODER_HALF_BIT_TICKS_DEF
) (
   input  logic clk,
   input  logic n_rst,
   input  logic run,
   output logic tick,
   output logic second_half
);

   localparam logic [7:0] LAST = 8'(HALF_BIT_TICKS - 1);

   logic [7:0] cnt;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt         <= '0;
         second_half <= 1'b0;
      end else if (!run) begin
         cnt         <= '0;
         second_half <= 1'b0;
      end else if (cnt == LAST) begin
         cnt         <= '0;
         second_half <= ~second_half;
      end else begin
         cnt <= cnt + 8'd1;
      end
   end

   assign tick = run && (cnt == LAST);

endmodule

// File: rtl/hsi_byte_coder.sv
// HSI byte coder: frames one byte (start, 8 data MSB first, optional odd parity, stop gap)
// and drives it Manchester-encoded. Parity is compiled in with HSI_CODER_PARITY_EN.
module hsi_byte_coder
   import hsi_byte_coder_pkg::*;
#(
   parameter int unsigned HALF_BIT_TICKS = CODER_HALF_BIT_TICKS_DEF
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       tx_en,
   input  logic [7:0] d,
   input  logic       d_rdy,
   output logic       cd_busy,
   output logic       sdo,
   output logic       sdo_oe,
   output logic       frame_done
);

   coder_state_t state;
   logic [7:0]   d_lat;
   logic [2:0]   bit_idx;
   logic         run;
   logic         tick;
   logic         second_half;
   logic         cur_bit;
`ifdef HSI_CODER_PARITY_EN
   logic         par_bit;
`endif

   assign run = (state != CODER_ST_IDLE);

   hsi_halfbit_tick #(
      .HALF_BIT_TICKS(HALF_BIT_TICKS)
   ) u_halfbit_tick (
      .clk         (clk),
      .n_rst       (n_rst),
      .run         (run),
      .tick        (tick),
      .second_half (second_half)
   );

   always_comb begin
      cur_bit = 1'b0;
      case (state)
         CODER_ST_START: cur_bit = CODER_START_BIT;
         CODER_ST_DATA:  cur_bit = d_lat[bit_idx];
`ifdef HSI_CODER_PARITY_EN
         CODER_ST_PAR:   cur_bit = par_bit;
`endif
         default:        cur_bit = 1'b0;
      endcase
   end

   // sdo is loaded one edge ahead: the first-half level of the next bit is set on the
   // edge that ends the current bit, so every output stays a plain register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= CODER_ST_IDLE;
         d_lat      <= '0;
         bit_idx    <= '0;
         cd_busy    <= 1'b0;
         sdo        <= 1'b0;
         sdo_oe     <= 1'b0;
         frame_done <= 1'b0;
`ifdef HSI_CODER_PARITY_EN
         par_bit    <= 1'b0;
`endif
      end else begin
         frame_done <= 1'b0;
         case (state)
            CODER_ST_IDLE: begin
               if (tx_en && d_rdy) begin
                  d_lat   <= d;
`ifdef HSI_CODER_PARITY_EN
                  par_bit <= odd_parity(d);
`endif
                  state   <= CODER_ST_START;
                  cd_busy <= 1'b1;
                  sdo_oe  <= 1'b1;
                  sdo     <= CODER_START_BIT;
               end
            end
            CODER_ST_STOP: begin
               if (tick && second_half) begin
                  state      <= CODER_ST_IDLE;
                  cd_busy    <= 1'b0;
                  frame_done <= 1'b1;
               end
            end
            default: begin
               if (tick) begin
                  if (!second_half) begin
                     sdo <= ~cur_bit;
                  end else begin
                     case (state)
                        CODER_ST_START: begin
                           state   <= CODER_ST_DATA;
                           bit_idx <= 3'd7;
                           sdo     <= d_lat[7];
                        end
                        CODER_ST_DATA: begin
                           if (bit_idx != 3'd0) begin
                              bit_idx <= bit_idx - 3'd1;
                              sdo     <= d_lat[bit_idx - 3'd1];
                           end else begin
`ifdef HSI_CODER_PARITY_EN
                              state <= CODER_ST_PAR;
                              sdo   <= par_bit;
`else
                              state  <= CODER_ST_STOP;
                              sdo    <= 1'b0;
                              sdo_oe <= 1'b0;
`endif
                           end
                        end
`ifdef HSI_CODER_PARITY_EN
                        CODER_ST_PAR: begin
                           state  <= CODER_ST_STOP;
                           sdo    <= 1'b0;
                           sdo_oe <= 1'b0;
                        end
`endif
                        default: ;
                     endcase
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hsi_byte_coder.sv
// Self-checking bench for hsi_byte_coder at HALF_BIT_TICKS=2; follows HSI_CODER_PARITY_EN.
module tb_hsi_byte_coder;

   localparam int H = 2;
`ifdef HSI_CODER_PARITY_EN
   localparam int NB = 11;
   localparam logic [63:0] EXP_A5 = 64'b10_10_01_10_01_01_10_01_10_10_00;
   localparam logic [63:0] EXP_3C = 64'b10_01_01_10_10_10_10_01_01_10_00;
`else
   localparam int NB = 10;
   localparam logic [63:0] EXP_A5 = 64'b10_10_01_10_01_01_10_01_10_00;
   localparam logic [63:0] EXP_3C = 64'b10_01_01_10_10_10_10_01_01_00;
`endif
   localparam int FL = NB * 2 * H;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       tx_en = 1'b0;
   logic       d_rdy = 1'b0;
   logic [7:0] d = '0;
   logic       cd_busy, sdo, sdo_oe, frame_done;

   int checks = 0;
   int errors = 0;

   hsi_byte_coder #(.HALF_BIT_TICKS(H)) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .tx_en      (tx_en),
      .d          (d),
      .d_rdy      (d_rdy),
      .cd_busy    (cd_busy),
      .sdo        (sdo),
      .sdo_oe     (sdo_oe),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Reference: queue of per-cycle {cd_busy, sdo, sdo_oe, frame_done} built from the frame rules.
   logic [3:0] exp_q[$];
   logic [3:0] cur = '0;

   task automatic push_frame(input logic [7:0] b);
      logic [0:NB-1] bits;
      bits = '0;
      bits[0] = 1'b1;
      for (int i = 0; i < 8; i++) bits[1+i] = b[7-i];
      if (NB == 11) bits[9] = ~^b;
      for (int i = 0; i < NB; i++)
         for (int k = 0; k < 2 * H; k++)
            if (i == NB - 1) exp_q.push_back(4'b1000);
            else exp_q.push_back({1'b1, (k < H) ? bits[i] : ~bits[i], 1'b1, 1'b0});
      exp_q.push_back(4'b0001);
   endtask

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         exp_q.delete();
         cur = '0;
      end else begin
         if (!cur[3] && tx_en && d_rdy) push_frame(d);
         cur = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
      end
   end

   always @(negedge clk) begin
      checks++;
      if ({cd_busy, sdo, sdo_oe, frame_done} !== cur) begin
         errors++;
         if (errors <= 20)
            $display("FAIL cycle_model t=%0t {cd_busy,sdo,sdo_oe,frame_done} actual=%b required=%b",
                     $time, {cd_busy, sdo, sdo_oe, frame_done}, cur);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic wait_busy(input string name);
      int n = 0;
      while (cd_busy !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(name, 64'(cd_busy), 64'd1);
   endtask

   // Called at the first negedge with cd_busy high; returns at the negedge where it reads 0.
   task automatic capture(input int drop_at, output logic [63:0] halves,
                          output int blen, output int dcnt);
      int i = 0;
      halves = '0;
      blen   = 0;
      dcnt   = 0;
      while (cd_busy === 1'b1 && i < 400) begin
         if (i % H == 0) halves = {halves[62:0], sdo};
         if (i == drop_at) tx_en = 1'b0;
         blen++;
         dcnt += int'(frame_done);
         i++;
         @(negedge clk);
      end
      dcnt += int'(frame_done);
   endtask

   initial begin
      logic [63:0] hv, hv0;
      int bl, dc, busy_cnt;

      // Reset held with a byte pending.
      n_rst = 1'b0; tx_en = 1'b1; d_rdy = 1'b1; d = 8'hA5;
      repeat (3) @(negedge clk);
      chk("reset_cd_busy", 64'(cd_busy), 64'd0);
      chk("reset_sdo", 64'(sdo), 64'd0);
      chk("reset_sdo_oe", 64'(sdo_oe), 64'd0);
      chk("reset_frame_done", 64'(frame_done), 64'd0);
      n_rst = 1'b1;
      @(negedge clk);
      chk("busy_after_release", 64'(cd_busy), 64'd1);
      d_rdy = 1'b0; d = 8'h00;
      capture(-1, hv, bl, dc);
      chk("a5_symbols", hv, EXP_A5);
      chk("a5_busy_len", 64'(bl), 64'(FL));
      chk("a5_done_count", 64'(dc), 64'd1);
      chk("a5_done_at_busy_low", 64'(frame_done), 64'd1);

      // Back-to-back 0x00 then 0xFF; producer advances on cd_busy rise.
      repeat (3) @(negedge clk);
      d = 8'h00; d_rdy = 1'b1; tx_en = 1'b1;
      wait_busy("b2b_first_start");
      d = 8'hFF;
      capture(-1, hv0, bl, dc);
      chk("b2b_00_busy_len", 64'(bl), 64'(FL));
      chk("b2b_00_data", 64'(hv0[2*NB-3 -: 16]), 64'h5555);
      @(negedge clk);
      chk("b2b_gap_one_clock", 64'(cd_busy), 64'd1);
      d_rdy = 1'b0;
      capture(-1, hv, bl, dc);
      chk("b2b_ff_busy_len", 64'(bl), 64'(FL));
      chk("b2b_ff_data", 64'(hv[2*NB-3 -: 16]), 64'hAAAA);
`ifdef HSI_CODER_PARITY_EN
      chk("b2b_00_parity", 64'(hv0[3:2]), 64'd2);
      chk("b2b_ff_parity", 64'(hv[3:2]), 64'd2);
`endif

      // tx_en dropped at clock 10 of a frame with d_rdy still high.
      repeat (3) @(negedge clk);
      d = 8'h5A; d_rdy = 1'b1; tx_en = 1'b1;
      wait_busy("txen_start");
      capture(10, hv, bl, dc);
      chk("txen_busy_len", 64'(bl), 64'(FL));
      chk("txen_done_count", 64'(dc), 64'd1);
      busy_cnt = 0;
      for (int i = 0; i < 3 * FL; i++) begin
         @(negedge clk);
         busy_cnt += int'(cd_busy);
      end
      chk("txen_no_reaccept", 64'(busy_cnt), 64'd0);

      // Asynchronous reset at clock 20 of a frame, then a fresh byte.
      tx_en = 1'b1; d = 8'hC3; d_rdy = 1'b1;
      wait_busy("rst_start");
      d_rdy = 1'b0;
      repeat (20) @(negedge clk);
      #1 n_rst = 1'b0;
      #1;
      chk("rst_async_cd_busy", 64'(cd_busy), 64'd0);
      chk("rst_async_sdo", 64'(sdo), 64'd0);
      chk("rst_async_sdo_oe", 64'(sdo_oe), 64'd0);
      @(negedge clk);
      n_rst = 1'b1; d = 8'h3C; d_rdy = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", 64'(cd_busy), 64'd1);
      d_rdy = 1'b0;
      capture(-1, hv, bl, dc);
      chk("post_rst_3c_symbols", hv, EXP_3C);
      chk("post_rst_busy_len", 64'(bl), 64'(FL));
      chk("post_rst_done_count", 64'(dc), 64'd1);

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

endmodule
